// File: rtl/irrig_pkg.sv
// rtl/irrig_pkg.sv - shared types and display constants for the irrigation scheduler
package irrig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATER = 2'd1,
        PAUSE = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_E     = 7'b1001111;

    function automatic logic [6:0] seg_of(input state_t s, input logic area);
        logic [6:0] r;
        r = SEG_BLANK;
        if (s == WATER) begin
            r = area ? SEG_1 : SEG_0;
        end else if (s == FAULT) begin
            r = SEG_E;
        end
        return r;
    endfunction

endpackage

// File: rtl/irrig_debounce.sv
// rtl/irrig_debounce.sv - two-flop synchroniser plus shared stability counter for the sensor vector
module irrig_debounce #(
    parameter int W   = 2,
    parameter int DEB = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic [W-1:0]  meta;
    logic [W-1:0]  u_s;
    logic [W-1:0]  u_last;
    logic [CW-1:0] cnt;

    // Any change in any bit restarts the shared count; the whole vector is accepted at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= '0;
            u_s    <= '0;
            u_last <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            meta <= raw;
            u_s  <= meta;
            if (u_s != u_last) begin
                u_last <= u_s;
                cnt    <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= u_last;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigacao_scheduler.sv
// rtl/irrigacao_scheduler.sv - round-robin pump/valve scheduler for two irrigation areas
module irrigacao_scheduler
    import irrig_pkg::*;
#(
    parameter int N_AREAS = 2,
    parameter int T_IRR   = 8,
    parameter int T_PAUSE = 2,
    parameter int DEB     = 3,
    parameter int R_MAX   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_AREAS-1:0] U,
    input  logic               enable,
    input  logic               fault_clr,
    output logic [N_AREAS-1:0] valve,
    output logic               pump,
    output logic               busy,
    output logic               fault,
    output logic [6:0]         seg
);

    localparam int T_MAX = (T_IRR > T_PAUSE) ? T_IRR : T_PAUSE;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int DW    = $clog2(R_MAX + 1);

    logic [N_AREAS-1:0]        u_d;
    state_t                    state, nstate;
    logic [TW-1:0]             timer, timer_n;
    logic                      area, area_n;
    logic                      last, last_n;
    logic [1:0][DW-1:0]        dry_cnt, dry_n;

    irrig_debounce #(
        .W   (N_AREAS),
        .DEB (DEB)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (U),
        .stable (u_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            area    <= 1'b0;
            last    <= 1'b1;
            dry_cnt <= '0;
            valve   <= '0;
            pump    <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            seg     <= SEG_BLANK;
        end else begin
            state   <= nstate;
            timer   <= timer_n;
            area    <= area_n;
            last    <= last_n;
            dry_cnt <= dry_n;
            valve   <= (nstate == WATER) ? (N_AREAS'(1) << area_n) : '0;
            pump    <= (nstate == WATER);
            busy    <= (nstate == WATER) || (nstate == PAUSE);
            fault   <= (nstate == FAULT);
            seg     <= seg_of(nstate, area_n);
        end
    end

    always_comb begin
        nstate  = state;
        timer_n = timer;
        area_n  = area;
        last_n  = last;
        dry_n   = dry_cnt;
        case (state)
            IDLE: begin
                if (enable && (u_d != '0)) begin
                    nstate  = WATER;
                    area_n  = (&u_d) ? ~last : u_d[1];
                    last_n  = area_n;
                    timer_n = TW'(T_IRR - 1);
                end
            end
            WATER: begin
                // An aborted grant is not a round, so the dry history is left alone.
                if (!enable) begin
                    nstate  = PAUSE;
                    timer_n = TW'(T_PAUSE - 1);
                end else if (timer == '0) begin
                    nstate  = PAUSE;
                    timer_n = TW'(T_PAUSE - 1);
                    if (!u_d[area]) begin
                        dry_n[area] = '0;
                    end else if (dry_cnt[area] == DW'(R_MAX - 1)) begin
                        dry_n[area] = DW'(R_MAX);
                        nstate      = FAULT;
                    end else begin
                        dry_n[area] = dry_cnt[area] + 1'b1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            PAUSE: begin
                if (timer == '0) begin
                    nstate = IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    nstate = IDLE;
                    dry_n  = '0;
                end
            end
            default: nstate = IDLE;
        endcase
    end

endmodule
